// File: rtl/logicnet_ens_vote.sv
// Ensemble vote for LogicNet classifiers.
// Per-class scores from NUM_ENS ensemble members are summed, one member per
// beat. The summed scores are then scanned one class per cycle to find the
// argmax, and the winning class and its score are held until the consumer
// takes them.
module logicnet_ens_vote #(
  parameter  int NUM_CLASSES = 10,
  parameter  int SCORE_W     = 2,
  parameter  int NUM_ENS     = 4,
  localparam int ACC_W       = SCORE_W + $clog2(NUM_ENS),
  localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLS_W-1:0]               out_class,
  output logic [ACC_W-1:0]               out_score
);

  localparam int CNT_W = $clog2(NUM_ENS);

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  // Set for one cycle after the final beat of a sample has been taken.
  // The scan starts in the cycle after that. The beat port stays closed
  // meanwhile so that no new beat can overwrite the finished sums.
  logic              r_last;
  logic [CLS_W-1:0]  r_idx;
  logic [CLS_W-1:0]  r_best_cls;
  logic [ACC_W-1:0]  r_best_score;
  logic [ACC_W-1:0]  r_acc [NUM_CLASSES];

  logic              w_accept;
  logic              w_scan_last;
  logic [ACC_W-1:0]  w_cand;
  logic [CLS_W-1:0]  w_best_cls;
  logic [ACC_W-1:0]  w_best_score;

  assign in_ready    = (r_state == ACCUM) && !r_last;
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == HOLD);
  assign w_scan_last = (r_idx == CLS_W'(NUM_CLASSES - 1));

  // Next-state logic: accumulate, then scan, then hold until the result is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (r_last)      w_next = SCAN;
      SCAN:    if (w_scan_last) w_next = HOLD;
      HOLD:    if (out_ready)   w_next = ACCUM;
      default:                  w_next = ACCUM;
    endcase
  end

  // Argmax step: class 0 seeds the best; later classes replace it only when strictly greater
  always_comb begin
    w_cand       = r_acc[r_idx];
    w_best_cls   = r_best_cls;
    w_best_score = r_best_score;
    if ((r_idx == '0) || (w_cand > r_best_score)) begin
      w_best_cls   = r_idx;
      w_best_score = w_cand;
    end
  end

  // Control state: FSM, member counter, scan index, running best and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_idx        <= '0;
      r_best_cls   <= '0;
      r_best_score <= '0;
      out_class    <= '0;
      out_score    <= '0;
    end else begin
      r_state <= w_next;
      if (r_last) begin
        r_last <= 1'b0;
      end else if (w_accept) begin
        if (r_cnt == CNT_W'(NUM_ENS - 1)) begin
          r_cnt  <= '0;
          r_last <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_state == SCAN) begin
        r_idx        <= w_scan_last ? '0 : r_idx + 1'b1;
        r_best_cls   <= w_best_cls;
        r_best_score <= w_best_score;
        if (w_scan_last) begin
          out_class <= w_best_cls;
          out_score <= w_best_score;
        end
      end
    end
  end

  // Per-class sums: the first beat of a sample loads and later beats add, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_acc[c] <= ((r_cnt == '0) ? '0 : r_acc[c]) +
                    ACC_W'(in_scores[c*SCORE_W +: SCORE_W]);
      end
    end
  end

endmodule

// File: tb/tb_logicnet_ens_vote.sv
// Bench for logicnet_ens_vote: directed samples with hand-computed winners.
// Expected results are queued as each sample is issued. A monitor pops and
// compares them whenever a result handshake occurs.
module tb_logicnet_ens_vote;
  localparam int NC    = 10;
  localparam int SW    = 2;
  localparam int NE    = 4;
  localparam int ACC_W = 4;
  localparam int CLS_W = 4;
  localparam int IW    = NC * SW;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IW-1:0]    in_scores;
  logic             out_valid;
  logic             out_ready;
  logic [CLS_W-1:0] out_class;
  logic [ACC_W-1:0] out_score;

  logicnet_ens_vote #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_ENS(NE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_scores(in_scores),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_score(out_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [CLS_W-1:0] c;
    logic [ACC_W-1:0] s;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   t_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int s);
    exp_t e;
    e.c = CLS_W'(c);
    e.s = ACC_W'(s);
    q.push_back(e);
  endtask

  // Beat with class c1 = v1 and (if c2 >= 0) class c2 = v2; all other classes 0
  function automatic logic [IW-1:0] mk2(input int c1, input int v1, input int c2, input int v2);
    logic [IW-1:0] r;
    r = '0;
    r[c1*SW +: SW] = v1[SW-1:0];
    if (c2 >= 0) r[c2*SW +: SW] = v2[SW-1:0];
    return r;
  endfunction

  // Offer one beat, wait (bounded) for in_ready, then idle for gap cycles
  task automatic send_beat(input logic [IW-1:0] s, input int gap);
    int k;
    in_valid  = 1'b1;
    in_scores = s;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) chk("in_ready_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send4(input logic [IW-1:0] b0, input logic [IW-1:0] b1,
                       input logic [IW-1:0] b2, input logic [IW-1:0] b3, input int gap);
    send_beat(b0, gap);
    send_beat(b1, gap);
    send_beat(b2, gap);
    send_beat(b3, gap);
  endtask

  // Wait (bounded) for out_valid; report cycles since the last accepted beat
  task automatic wait_valid(output int lat);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (k == 100) chk("out_valid_timeout", int'(out_valid), 1);
    lat = cyc - t_acc;
  endtask

  // Wait (bounded) until every queued result has been consumed
  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    if (k == 300) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each result handshake, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: class %0d score %0d, expected none", out_class, out_score);
        end else begin
          e = q.pop_front();
          chk("out_class", int'(out_class), int'(e.c));
          chk("out_score", int'(out_score), int'(e.s));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_scores = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_score", int'(out_score), 0);
    @(posedge clk);
    #1;

    // Basic: class 7 gets 3 from every member
    push(7, 12);
    send4(mk2(7,3,-1,0), mk2(7,3,-1,0), mk2(7,3,-1,0), mk2(7,3,-1,0), 0);
    wait_valid(lat);
    chk("latency", lat, NC + 1);
    drain();

    // Tie between classes 2 and 5 resolves to the lower index
    push(2, 6);
    send4(mk2(2,3,5,2), mk2(2,3,5,3), mk2(5,1,0,2), mk2(0,1,9,3), 0);
    drain();

    // A later class with a strictly larger sum wins
    push(8, 11);
    send4(mk2(3,1,8,3), mk2(3,1,8,3), mk2(3,1,8,3), mk2(3,1,8,2), 0);
    drain();

    // All classes at maximum: every class ties, so class 0 wins with 12
    push(0, 12);
    send4({NC{2'b11}}, {NC{2'b11}}, {NC{2'b11}}, {NC{2'b11}}, 0);
    drain();

    // Back-pressure: hold the result 20 cycles while junk is offered on the input
    out_ready = 1'b0;
    push(4, 6);
    send4(mk2(4,2,1,1), mk2(4,1,1,1), mk2(4,0,1,1), mk2(4,3,1,1), 0);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_scores = mk2(9,3,-1,0);
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_class", int'(out_class), 4);
      chk("bp_out_score", int'(out_score), 6);
      chk("bp_in_ready",  int'(in_ready),  0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready",  int'(in_ready),  1);
    chk("post_hs_out_valid", int'(out_valid), 0);
    chk("post_hs_out_class", int'(out_class), 4);
    chk("post_hs_out_score", int'(out_score), 6);
    @(posedge clk);
    #1;

    // Gapped beats, two samples back to back; the second must not inherit the first's sums
    push(6, 12);
    push(1, 4);
    send4(mk2(6,3,1,2), mk2(6,3,1,2), mk2(6,3,1,2), mk2(6,3,1,2), 1);
    send4(mk2(1,1,-1,0), mk2(1,1,-1,0), mk2(1,1,-1,0), mk2(1,1,-1,0), 1);
    drain();

    // Reset after two beats discards the partial sample
    send_beat(mk2(3,3,-1,0), 0);
    send_beat(mk2(3,3,-1,0), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 0);
    send4('0, '0, '0, '0, 0);
    drain();

    // Reset during scan cycle 5 produces no result
    send4(mk2(9,3,-1,0), mk2(9,3,-1,0), mk2(9,3,-1,0), mk2(9,3,-1,0), 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("scan_rst_no_out", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    push(0, 0);
    send4('0, '0, '0, '0, 0);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/logicnet_ens_vote.md
LOGICNET_ENS_VOTE -- requirements
Module: logicnet_ens_vote

Interface
REQ-001 The block SHALL take parameter NUM_CLASSES, default 10: number of class scores per ensemble member.
REQ-002 The block SHALL take parameter SCORE_W, default 2: width of each unsigned per-class score from a member's final layer.
REQ-003 The block SHALL take parameter NUM_ENS, default 4 (legal range 2..16): ensemble members per sample.
REQ-004 The block SHALL derive localparam ACC_W = SCORE_W + clog2(NUM_ENS) and CLS_W = clog2(NUM_CLASSES).
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1: in_scores holds one member's scores.
REQ-008 The block SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-009 The block SHALL have port in_scores, input, NUM_CLASSES*SCORE_W: class c occupies bits [c*SCORE_W +: SCORE_W].
REQ-010 The block SHALL have port out_valid, output, 1: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-012 The block SHALL have port out_class, output, CLS_W: the winning class index.
REQ-013 The block SHALL have port out_score, output, ACC_W: the winning class's accumulated score.

Function
REQ-014 The block SHALL implement a three-state FSM with states ACCUM, SCAN and HOLD; ACCUM is the reset state.
REQ-015 A beat SHALL be accepted only when in_valid and in_ready are both high; in_ready SHALL be 1 only in ACCUM.
REQ-016 In ACCUM, a member counter SHALL count accepted beats from 0 to NUM_ENS-1.
REQ-017 The first beat of a sample (count 0) SHALL load each per-class accumulator with its zero-extended score; each later beat SHALL add to the accumulators.
REQ-018 Accumulation SHALL be unsigned, with no overflow possible at width ACC_W.
REQ-019 On acceptance of beat NUM_ENS-1, the FSM SHALL enter SCAN on the next cycle and the member counter SHALL clear.
REQ-020 SCAN SHALL visit one class per cycle, index 0 through NUM_CLASSES-1, for exactly NUM_CLASSES cycles.
REQ-021 SCAN SHALL initialise best to class 0 on its first cycle; a later class SHALL replace best only if its score is strictly greater (ties resolve to the lowest index).
REQ-022 After the last SCAN cycle the FSM SHALL enter HOLD, with out_valid=1 and out_class/out_score driven from registers.
REQ-023 Latency SHALL be fixed: if the final beat is accepted at edge t, out_valid SHALL rise after edge t+NUM_CLASSES+1.
REQ-024 In HOLD, out_class and out_score SHALL stay stable until the out_valid && out_ready handshake completes.
REQ-025 On that handshake the FSM SHALL return to ACCUM on the next cycle; back-pressure of any length SHALL be tolerated.
REQ-026 When not in HOLD, out_valid SHALL be 0; out_class and out_score SHALL keep their last values.
REQ-027 in_valid with in_ready low SHALL have no effect; the upstream holds the data.
REQ-028 in_valid deasserted between beats of a sample SHALL pause accumulation without losing partial sums.

Reset
REQ-029 When rst is high at a clock edge: FSM=ACCUM, member counter=0, out_valid=0, out_class=0, out_score=0, best registers=0, and in_ready=1 from the following cycle.
REQ-030 Reset SHALL take priority over every handshake in the same cycle; a reset mid-sample or mid-SCAN SHALL discard the partial sample, with no output produced.
REQ-031 Accumulators need no reset, because the first-beat load (REQ-017) overwrites them.

Verification
REQ-032 Basic: 4 beats, each with class 7 = 3 and all others 0 -> out_class=7, out_score=12, out_valid rises 11 cycles after the 4th acceptance.
REQ-033 Tie: beat sums give class 2 = 6 and class 5 = 6, all others lower -> out_class=2, out_score=6.
REQ-034 Back-pressure: out_ready held low 20 cycles in HOLD -> out_valid and outputs stable, in_ready=0, in_valid ignored; one cycle after out_ready=1, in_ready=1.
REQ-035 Gaps/back-to-back: in_valid toggled 1,0,1,0,... across two samples -> both results correct; sample 2's first beat loads rather than adds (no carry-over from sample 1).
REQ-036 Reset mid-operation: rst asserted after 2 beats, and separately at SCAN cycle 5 -> no out_valid; a following full sample (all scores 0) -> out_class=0, out_score=0.
